fmul_seq: RTL and testbench



---
 rtl/fmul_seq.sv | 259 +++++++++++++++++++++++++
 tb/tb_fmul_seq.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_seq.sv
// fmul_seq: sequential IEEE-754-style floating-point multiplier.
//
// Significands are multiplied by a shift-add datapath, one multiplier bit per
// cycle, followed by a single normalise/round/classify cycle. Operands and
// results move through valid/ready handshakes; one operation is in flight at
// a time.
//
// Optional feature macro: FMUL_ROUND_NEAREST_EN
//   defined   -> round-to-nearest-even from guard and sticky bits
//   undefined -> truncation (round toward zero), no rounding logic
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   in_valid / in_ready             operand handshake
//   in_Sign_*, in_Exponent_*,
//   in_Mantissa_*                   operand fields (biased exponent, stored mantissa)
//   out_valid / out_ready           result handshake
//   out_Sign, out_Exponent,
//   out_Mantissa                    result fields, held stable while out_valid=1
//   SC_Exponent_Overflow            result overflowed to infinity
//   SC_Exponent_Underflow           result flushed to zero
//   SC_Invalid                      NaN operand or 0 x inf
module fmul_seq #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_Sign_1,
  input  logic             in_Sign_2,
  input  logic [EXP_W-1:0] in_Exponent_1,
  input  logic [EXP_W-1:0] in_Exponent_2,
  input  logic [MAN_W-1:0] in_Mantissa_1,
  input  logic [MAN_W-1:0] in_Mantissa_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_Sign,
  output logic [EXP_W-1:0] out_Exponent,
  output logic [MAN_W-1:0] out_Mantissa,
  output logic             SC_Exponent_Overflow,
  output logic             SC_Exponent_Underflow,
  output logic             SC_Invalid
);

  localparam int unsigned SigW  = MAN_W + 1;
  localparam int unsigned ProdW = 2 * SigW;
  localparam int unsigned EW    = EXP_W + 2;
  localparam int unsigned CntW  = $clog2(MAN_W + 2);

  // Counter values 0..MAN_W perform the shift-add steps; the final value is a
  // drain cycle that gives the fixed MAN_W+3 edge result latency.
  localparam logic [CntW-1:0]      LastCnt = CntW'(MAN_W + 1);
  localparam logic signed [EW-1:0] Bias    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] MaxExp  = EW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;

  state_e state_q, state_d;

  // ---------------------------------------------------------------------------
  // Operand classification (evaluated on the accept edge only)
  // ---------------------------------------------------------------------------
  logic accept;
  logic zero1, zero2, inf1, inf2, nan1, nan2;
  logic signed [EW-1:0] e_sum_in;

  assign accept = (state_q == StIdle) && in_valid;

  always_comb begin
    zero1    = ~|in_Exponent_1;
    zero2    = ~|in_Exponent_2;
    inf1     = (&in_Exponent_1) && ~|in_Mantissa_1;
    inf2     = (&in_Exponent_2) && ~|in_Mantissa_2;
    nan1     = (&in_Exponent_1) && |in_Mantissa_1;
    nan2     = (&in_Exponent_2) && |in_Mantissa_2;
    e_sum_in = $signed(EW'(in_Exponent_1)) + $signed(EW'(in_Exponent_2)) - Bias;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  logic                 sign_q, invalid_q, inf_q, zero_q;
  logic signed [EW-1:0] e_sum_q;
  logic [SigW-1:0]      mcand_q, mplier_q;
  logic [ProdW-1:0]     acc_q;
  logic [CntW-1:0]      cnt_q;

  logic                 step_en;
  logic [SigW:0]        partial;
  logic [ProdW-1:0]     acc_step;

  // Add the multiplicand into the upper half when the multiplier LSB is set,
  // then shift the whole accumulator right by one.
  always_comb begin
    step_en  = (cnt_q != LastCnt);
    partial  = {1'b0, acc_q[ProdW-1:SigW]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {partial, acc_q[SigW-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q    <= 1'b0;
      invalid_q <= 1'b0;
      inf_q     <= 1'b0;
      zero_q    <= 1'b0;
      e_sum_q   <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else if (accept) begin
      sign_q    <= in_Sign_1 ^ in_Sign_2;
      invalid_q <= nan1 | nan2 | (zero1 & inf2) | (inf1 & zero2);
      inf_q     <= inf1 | inf2;
      zero_q    <= zero1 | zero2;
      e_sum_q   <= e_sum_in;
      // Subnormal mantissas are loaded too, but zero_q overrides the result.
      mcand_q   <= {1'b1, in_Mantissa_1};
      mplier_q  <= {1'b1, in_Mantissa_2};
      acc_q     <= '0;
      cnt_q     <= '0;
    end else if (state_q == StMul) begin
      cnt_q <= cnt_q + CntW'(1);
      if (step_en) begin
        acc_q    <= acc_step;
        mplier_q <= mplier_q >> 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Normalise and round
  // ---------------------------------------------------------------------------
  logic                 prod_hi;
  logic [MAN_W-1:0]     man_t, man_r;
  logic                 rnd_carry;
  logic signed [EW-1:0] e_fin;

`ifdef FMUL_ROUND_NEAREST_EN
  logic guard, sticky, round_up;

  always_comb begin
    prod_hi  = acc_q[ProdW-1];
    man_t    = prod_hi ? acc_q[ProdW-2 -: MAN_W] : acc_q[ProdW-3 -: MAN_W];
    guard    = prod_hi ? acc_q[MAN_W] : acc_q[MAN_W-1];
    sticky   = prod_hi ? |acc_q[MAN_W-1:0] : |acc_q[MAN_W-2:0];
    // Round up above half, or exactly at half when the kept LSB is odd.
    round_up = guard & (sticky | man_t[0]);
    {rnd_carry, man_r} = {1'b0, man_t} + {{MAN_W{1'b0}}, round_up};
    // A carry out means the significand became 10.000..; the stored mantissa
    // is already zero, so only the exponent needs the extra increment.
    e_fin    = e_sum_q + EW'(prod_hi) + EW'(rnd_carry);
  end
`else
  logic unused_acc_lsb;

  assign unused_acc_lsb = acc_q[0];

  always_comb begin
    prod_hi   = acc_q[ProdW-1];
    man_t     = prod_hi ? acc_q[ProdW-2 -: MAN_W] : acc_q[ProdW-3 -: MAN_W];
    man_r     = man_t;
    rnd_carry = 1'b0;
    e_fin     = e_sum_q + EW'(prod_hi) + EW'(rnd_carry);
  end
`endif

  // ---------------------------------------------------------------------------
  // Result selection in priority order
  // ---------------------------------------------------------------------------
  logic             res_sign, res_ov, res_un, res_inv;
  logic [EXP_W-1:0] res_exp;
  logic [MAN_W-1:0] res_man;

  always_comb begin
    res_sign = sign_q;
    res_exp  = e_fin[EXP_W-1:0];
    res_man  = man_r;
    res_ov   = 1'b0;
    res_un   = 1'b0;
    res_inv  = 1'b0;
    if (invalid_q) begin
      res_sign = 1'b0;
      res_exp  = '1;
      res_man  = {1'b1, {(MAN_W - 1){1'b0}}};
      res_inv  = 1'b1;
    end else if (inf_q) begin
      res_exp = '1;
      res_man = '0;
    end else if (zero_q) begin
      res_exp = '0;
      res_man = '0;
    end else if (!e_fin[EW-1] && (e_fin >= MaxExp)) begin
      res_exp = '1;
      res_man = '0;
      res_ov  = 1'b1;
    end else if (e_fin[EW-1] || (e_fin == '0)) begin
      res_exp = '0;
      res_man = '0;
      res_un  = 1'b1;
    end
  end

  // Output registers: loaded in NORM, cleared when the result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_Sign              <= 1'b0;
      out_Exponent          <= '0;
      out_Mantissa          <= '0;
      SC_Exponent_Overflow  <= 1'b0;
      SC_Exponent_Underflow <= 1'b0;
      SC_Invalid            <= 1'b0;
    end else if (state_q == StNorm) begin
      out_Sign              <= res_sign;
      out_Exponent          <= res_exp;
      out_Mantissa          <= res_man;
      SC_Exponent_Overflow  <= res_ov;
      SC_Exponent_Underflow <= res_un;
      SC_Invalid            <= res_inv;
    end else if ((state_q == StDone) && out_ready) begin
      out_Sign              <= 1'b0;
      out_Exponent          <= '0;
      out_Mantissa          <= '0;
      SC_Exponent_Overflow  <= 1'b0;
      SC_Exponent_Underflow <= 1'b0;
      SC_Invalid            <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StMul;
      StMul:  if (cnt_q == LastCnt) state_d = StNorm;
      StNorm: state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

endmodule

// File: tb/tb_fmul_seq.sv
// Self-checking bench for fmul_seq (half precision defaults). Expected results
// come from directed constants and an integer-arithmetic reference model.
module tb_fmul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_Sign_1 = 1'b0, in_Sign_2 = 1'b0;
  logic [4:0]  in_Exponent_1 = '0, in_Exponent_2 = '0;
  logic [9:0]  in_Mantissa_1 = '0, in_Mantissa_2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_Sign;
  logic [4:0]  out_Exponent;
  logic [9:0]  out_Mantissa;
  logic        SC_Exponent_Overflow, SC_Exponent_Underflow, SC_Invalid;

  int n_cmp  = 0;
  int n_fail = 0;

  fmul_seq #(.EXP_W(5), .MAN_W(10)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .in_Sign_1             (in_Sign_1),
    .in_Sign_2             (in_Sign_2),
    .in_Exponent_1         (in_Exponent_1),
    .in_Exponent_2         (in_Exponent_2),
    .in_Mantissa_1         (in_Mantissa_1),
    .in_Mantissa_2         (in_Mantissa_2),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_Sign              (out_Sign),
    .out_Exponent          (out_Exponent),
    .out_Mantissa          (out_Mantissa),
    .SC_Exponent_Overflow  (SC_Exponent_Overflow),
    .SC_Exponent_Underflow (SC_Exponent_Underflow),
    .SC_Invalid            (SC_Invalid)
  );

  always #5 clk = ~clk;

  // Returns {overflow, underflow, invalid, result[15:0]}.
  function automatic logic [18:0] model_mul(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, p, sh, e, m;
    bit s, za, zb, ia, ib, na, nb;
`ifdef FMUL_ROUND_NEAREST_EN
    int rem, half;
`endif
    ea = int'(a[14:10]); ma = int'(a[9:0]);
    eb = int'(b[14:10]); mb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    za = (ea == 0);              zb = (eb == 0);
    ia = (ea == 31) && (ma == 0); ib = (eb == 31) && (mb == 0);
    na = (ea == 31) && (ma != 0); nb = (eb == 31) && (mb != 0);
    if (na || nb || (za && ib) || (ia && zb)) return {3'b001, 16'h7E00};
    if (ia || ib) return {3'b000, s, 5'h1F, 10'h000};
    if (za || zb) return {3'b000, s, 15'h0000};
    p  = (1024 + ma) * (1024 + mb);
    sh = (p >= (1 << 21)) ? 11 : 10;
    e  = ea + eb - 15 + (sh - 10);
    m  = p >> sh;
`ifdef FMUL_ROUND_NEAREST_EN
    rem  = p % (1 << sh);
    half = 1 << (sh - 1);
    if ((rem > half) || ((rem == half) && (m % 2 == 1))) m = m + 1;
    if (m == 2048) begin
      m = 1024;
      e = e + 1;
    end
`endif
    if (e >= 31) return {3'b100, s, 5'h1F, 10'h000};
    if (e <= 0) return {3'b010, s, 15'h0000};
    return {3'b000, s, 5'(e), 10'(m)};
  endfunction

  function automatic logic [18:0] observed();
    return {SC_Exponent_Overflow, SC_Exponent_Underflow, SC_Invalid,
            out_Sign, out_Exponent, out_Mantissa};
  endfunction

  // Drive one operand pair; returns after the accept edge. waited = cycles spent
  // waiting for in_ready; ok = 0 if in_ready never came.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       output bit ok, output int waited);
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    ok = in_ready;
    if (!ok) return;
    {in_Sign_1, in_Exponent_1, in_Mantissa_1} = a;
    {in_Sign_2, in_Exponent_2, in_Mantissa_2} = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble operands: they must not matter after the accept edge.
    {in_Sign_1, in_Exponent_1, in_Mantissa_1} = 16'($urandom);
    {in_Sign_2, in_Exponent_2, in_Mantissa_2} = 16'($urandom);
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_result(output int lat, output logic [18:0] got, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    got = observed();
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [18:0] got, output int lat, output bit ok);
    int  waited;
    bit  ok_i, ok_w;
    issue(a, b, ok_i, waited);
    if (!ok_i) begin
      ok = 1'b0; lat = 0; got = 'x;
      return;
    end
    wait_result(lat, got, ok_w);
    ok = ok_w;
    if (ok_w) pop();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, observed()} !== {2'b10, 19'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b out=%h want rdy=1 vld=0 out=0",
               in_ready, out_valid, observed());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] va[3] = '{16'h3C00, 16'h3E00, 16'hC000};
    logic [15:0] vb[3] = '{16'h3C00, 16'h3E00, 16'h4200};
    logic [18:0] ve[3] = '{19'h03C00, 19'h04080, 19'h0C600};
    logic [18:0] got;
    int lat;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], got, lat, ok);
      n_cmp++;
      if (!ok || got !== ve[i]) begin
        n_fail++;
        $display("FAIL basic_%0d: %h x %h got %h want %h (ok=%b)", i, va[i], vb[i], got, ve[i], ok);
      end
      n_cmp++;
      if (lat != 13) begin
        n_fail++;
        $display("FAIL basic_latency_%0d: got %0d edges want 13", i, lat);
      end
    end
  endtask

  task automatic test_rounding();
    logic [18:0] got, want;
    int lat;
    bit ok;
`ifdef FMUL_ROUND_NEAREST_EN
    want = 19'h03E02;
`else
    want = 19'h03E01;
`endif
    run_op(16'h3C01, 16'h3E00, got, lat, ok);
    n_cmp++;
    if (!ok || got !== want) begin
      n_fail++;
      $display("FAIL rounding: got %h want %h (ok=%b)", got, want, ok);
    end
  endtask

  task automatic test_specials();
    logic [15:0] va[6] = '{16'h7800, 16'h0400, 16'h7C00, 16'h8000, 16'h7C01, 16'hFC00};
    logic [15:0] vb[6] = '{16'h7800, 16'h0400, 16'h0000, 16'h4000, 16'h3C00, 16'h3C00};
    logic [18:0] ve[6] = '{19'h47C00, 19'h20000, 19'h17E00, 19'h08000, 19'h17E00, 19'h0FC00};
    logic [18:0] got;
    int lat;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], got, lat, ok);
      n_cmp++;
      if (!ok || got !== ve[i] || lat != 13) begin
        n_fail++;
        $display("FAIL special_%0d: %h x %h got %h lat %0d want %h lat 13",
                 i, va[i], vb[i], got, lat, ve[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic [18:0] got, want;
    int lat;
    bit ok;
    for (int i = 0; i < 200; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      // Bias most operands toward mid-range exponents so normal products dominate.
      if ($urandom_range(0, 3) != 0) a[14:10] = 5'($urandom_range(8, 22));
      if ($urandom_range(0, 3) != 0) b[14:10] = 5'($urandom_range(8, 22));
      want = model_mul(a, b);
      run_op(a, b, got, lat, ok);
      n_cmp++;
      if (!ok || got !== want || lat != 13) begin
        n_fail++;
        $display("FAIL random_%0d: %h x %h got %h lat %0d want %h lat 13",
                 i, a, b, got, lat, want);
      end
    end
  endtask

  task automatic test_hold_and_back_to_back();
    logic [18:0] got, snap, want;
    int lat, waited;
    bit ok;
    issue(16'h7800, 16'h7800, ok, waited);
    wait_result(lat, snap, ok);
    n_cmp++;
    if (!ok || snap !== 19'h47C00) begin
      n_fail++;
      $display("FAIL hold_result: got %h want %h (ok=%b)", snap, 19'h47C00, ok);
    end
    // Hold out_ready low and try to push a second operation.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      {in_Sign_1, in_Exponent_1, in_Mantissa_1} = 16'($urandom);
      {in_Sign_2, in_Exponent_2, in_Mantissa_2} = 16'($urandom);
      @(posedge clk);
      #1;
      n_cmp++;
      if (observed() !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_cycle_%0d: got out=%h rdy=%b vld=%b want out=%h rdy=0 vld=1",
                 i, observed(), in_ready, out_valid, snap);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    pop();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || observed() !== 19'h0) begin
      n_fail++;
      $display("FAIL release: got rdy=%b vld=%b out=%h want rdy=1 vld=0 out=0",
               in_ready, out_valid, observed());
    end
    // Immediately issue the next op; it must be accepted without waiting.
    want = model_mul(16'hC000, 16'h4200);
    issue(16'hC000, 16'h4200, ok, waited);
    n_cmp++;
    if (!ok || waited != 0) begin
      n_fail++;
      $display("FAIL back_to_back_accept: waited %0d cycles want 0 (ok=%b)", waited, ok);
    end
    wait_result(lat, got, ok);
    if (ok) pop();
    n_cmp++;
    if (!ok || got !== want || lat != 13) begin
      n_fail++;
      $display("FAIL back_to_back_result: got %h lat %0d want %h lat 13", got, lat, want);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [18:0] got, want;
    int lat, waited;
    bit ok, seen;
    // Reset during MUL cycle 5.
    issue(16'h3E00, 16'h3E00, ok, waited);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, observed()} !== {2'b10, 19'h0}) begin
      n_fail++;
      $display("FAIL reset_mid_mul: got rdy=%b vld=%b out=%h want rdy=1 vld=0 out=0",
               in_ready, out_valid, observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_discard: got leftover activity=1 want 0");
    end
    // Reset while a flagged result is held.
    issue(16'h7C00, 16'h0000, ok, waited);
    wait_result(lat, got, ok);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, observed()} !== {2'b10, 19'h0}) begin
      n_fail++;
      $display("FAIL reset_in_done: got rdy=%b vld=%b out=%h want rdy=1 vld=0 out=0",
               in_ready, out_valid, observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
    want = model_mul(16'h3C01, 16'hBE00);
    run_op(16'h3C01, 16'hBE00, got, lat, ok);
    n_cmp++;
    if (!ok || got !== want || lat != 13) begin
      n_fail++;
      $display("FAIL after_reset_op: got %h lat %0d want %h lat 13", got, lat, want);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_random();
    test_hold_and_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
